// File: rtl/hazard_controller_if.sv
// Interface bundle for hazard_controller: pipeline state in, stall/flush/forward/counters out.
// The master drives the pipeline-state inputs; the slave (the controller) drives the rest.
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             MemReadEnE, PCSF, RegWriteEnM, MemBusyM, RegWriteEnW;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output MemReadEnE, PCSF, RegWriteEnM, MemBusyM, RegWriteEnW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  MemReadEnE, PCSF, RegWriteEnM, MemBusyM, RegWriteEnW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard/sequencing unit for the 5-stage RV64 pipeline: forwarding, load-use stall,
// branch flush, data-memory wait FSM with timeout/sticky error, saturating perf counters.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave bus
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_load_use;
  logic w_stall_all;
  logic w_stall_fd;
  logic w_flush_d;
  logic w_flush_e;

  // Producer in M is younger than the one in W, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteEnM, bus.RdW, bus.RegWriteEnW);
  assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteEnM, bus.RdW, bus.RegWriteEnW);

  assign w_load_use = bus.MemReadEnE && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // RUN and a MEM_WAIT cycle whose memory has just become ready behave identically,
  // so only the error state and MemBusyM need to be distinguished here.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_stall_all = 1'b0;
    w_stall_fd  = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    if (!rst) begin
      if ((r_state == ST_MEM_ERR) || bus.MemBusyM) begin
        w_stall_all = 1'b1;
      end else if (w_load_use) begin
        w_stall_fd = 1'b1;
        w_flush_e  = 1'b1;
      end else if (bus.PCSF) begin
        w_flush_d = 1'b1;
      end
    end
  end

  assign bus.StallF = w_stall_all | w_stall_fd;
  assign bus.StallD = w_stall_all | w_stall_fd;
  assign bus.StallE = w_stall_all;
  assign bus.StallM = w_stall_all;
  assign bus.FlushW = w_stall_all;
  assign bus.FlushD = w_flush_d;
  assign bus.FlushE = w_flush_e;

  assign bus.MemErr   = r_mem_err;
  assign bus.StallCnt = r_stall_cnt;
  assign bus.FlushCnt = r_flush_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.MemBusyM) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.MemBusyM) begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
            // The incremented count reaching MEM_TIMEOUT means the budget is spent.
            if (r_wait_cnt == WAIT_LAST) begin
              r_state   <= ST_MEM_ERR;
              r_mem_err <= 1'b1;
            end
          end else begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end
        end
        ST_MEM_ERR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase

      if (bus.StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if ((w_flush_d || w_flush_e) && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a default instance (64/32) and a small one
// (MEM_TIMEOUT=4, CNT_W=3) share stimulus so timeout and saturation are reachable quickly.
module tb_hazard_controller;

  logic clk;
  logic rst;

  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       mem_read_e, pcsf, we_m, mem_busy, we_w;

  int n_vec;
  int n_err;

  hazard_controller_if #(.CNT_W(32)) hif0 ();
  hazard_controller_if #(.CNT_W(3))  hif1 ();

  assign hif0.Rs1D = rs1d;        assign hif1.Rs1D = rs1d;
  assign hif0.Rs2D = rs2d;        assign hif1.Rs2D = rs2d;
  assign hif0.Rs1E = rs1e;        assign hif1.Rs1E = rs1e;
  assign hif0.Rs2E = rs2e;        assign hif1.Rs2E = rs2e;
  assign hif0.RdE  = rde;         assign hif1.RdE  = rde;
  assign hif0.RdM  = rdm;         assign hif1.RdM  = rdm;
  assign hif0.RdW  = rdw;         assign hif1.RdW  = rdw;
  assign hif0.MemReadEnE  = mem_read_e;  assign hif1.MemReadEnE  = mem_read_e;
  assign hif0.PCSF        = pcsf;        assign hif1.PCSF        = pcsf;
  assign hif0.RegWriteEnM = we_m;        assign hif1.RegWriteEnM = we_m;
  assign hif0.MemBusyM    = mem_busy;    assign hif1.MemBusyM    = mem_busy;
  assign hif0.RegWriteEnW = we_w;        assign hif1.RegWriteEnW = we_w;

  hazard_controller #(.MEM_TIMEOUT(64), .CNT_W(32)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (hif0.slave)
  );

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (hif1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0;
    rde  = '0; rdm  = '0; rdw  = '0;
    mem_read_e = 1'b0; pcsf = 1'b0; we_m = 1'b0; mem_busy = 1'b0; we_w = 1'b0;
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset: stalls held low even with memory busy, state registers cleared.
    mem_busy = 1'b1;
    #2;
    check("rst_stallf",   32'(hif0.StallF),   0);
    check("rst_flushw",   32'(hif0.FlushW),   0);
    check("rst_memerr",   32'(hif0.MemErr),   0);
    check("rst_stallcnt", 32'(hif0.StallCnt), 0);
    check("rst_flushcnt", 32'(hif0.FlushCnt), 0);
    mem_busy = 1'b0;
    tick();
    rst = 1'b0;

    // Forwarding: M beats W, x0 ignored, B path independent.
    rdm = 5'd5; we_m = 1'b1; rs1e = 5'd5; rdw = 5'd5; we_w = 1'b1;
    #1;
    check("fwd_a_m",    32'(hif0.ForwardAE), 32'h2);
    check("fwd_b_none", 32'(hif0.ForwardBE), 32'h0);
    rdm = 5'd0;
    #1;
    check("fwd_a_w",    32'(hif0.ForwardAE), 32'h1);
    clear_inputs();
    rs2e = 5'd5; rdm = 5'd5; we_m = 1'b1;
    #1;
    check("fwd_b_m",    32'(hif0.ForwardBE), 32'h2);
    check("fwd_a_none", 32'(hif0.ForwardAE), 32'h0);
    we_m = 1'b0; rdw = 5'd5; we_w = 1'b1;
    #1;
    check("fwd_b_w",    32'(hif0.ForwardBE), 32'h1);
    clear_inputs();
    we_m = 1'b1; we_w = 1'b1;
    #1;
    check("fwd_x0",     32'({hif0.ForwardAE, hif0.ForwardBE}), 32'h0);
    check("fwd_nostall", 32'(hif0.StallF), 0);
    clear_inputs();

    // Load-use beats a taken branch for one cycle.
    mem_read_e = 1'b1; rde = 5'd3; rs2d = 5'd3; pcsf = 1'b1;
    #1;
    check("lu_stallf", 32'(hif0.StallF), 1);
    check("lu_stalld", 32'(hif0.StallD), 1);
    check("lu_flushe", 32'(hif0.FlushE), 1);
    check("lu_flushd", 32'(hif0.FlushD), 0);
    check("lu_stalle", 32'(hif0.StallE), 0);
    tick();
    clear_inputs();
    check("lu_stallcnt", 32'(hif0.StallCnt), 1);
    check("lu_flushcnt", 32'(hif0.FlushCnt), 1);
    mem_read_e = 1'b1; rde = 5'd0;
    #1;
    check("lu_x0", 32'(hif0.StallF), 0);
    clear_inputs();

    // Taken branch alone.
    pcsf = 1'b1;
    #1;
    check("br_flushd", 32'(hif0.FlushD), 1);
    check("br_stallf", 32'(hif0.StallF), 0);
    check("br_flushe", 32'(hif0.FlushE), 0);
    tick();
    clear_inputs();
    check("br_flushcnt", 32'(hif0.FlushCnt), 2);
    check("br_stallcnt", 32'(hif0.StallCnt), 1);

    // Memory wait for 3 cycles with a branch pending; release with the branch still set.
    do_reset();
    mem_busy = 1'b1; pcsf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stallall", 32'({hif0.StallF, hif0.StallD, hif0.StallE, hif0.StallM, hif0.FlushW}), 32'h1f);
      check("mw_noflushd", 32'(hif0.FlushD), 0);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    check("mw_release_stall", 32'({hif0.StallF, hif0.StallM, hif0.FlushW}), 0);
    check("mw_release_flushd", 32'(hif0.FlushD), 1);
    tick();
    clear_inputs();
    check("mw_stallcnt", 32'(hif0.StallCnt), 3);
    check("mw_flushcnt", 32'(hif0.FlushCnt), 1);
    check("mw_below_timeout", 32'(hif1.MemErr), 0);
    #1;
    check("mw_back_run", 32'(hif1.StallF), 0);

    // Timeout on the small instance after 4 busy cycles; error is sticky.
    do_reset();
    mem_busy = 1'b1;
    tick(); tick(); tick();
    check("to_not_yet", 32'(hif1.MemErr), 0);
    tick();
    check("to_memerr", 32'(hif1.MemErr), 1);
    mem_busy = 1'b0;
    #1;
    check("to_err_stall", 32'({hif1.StallF, hif1.StallM, hif1.FlushW}), 32'h7);
    check("to_big_run",   32'(hif0.StallF), 0);
    tick();
    check("to_sticky",    32'(hif1.MemErr), 1);
    mem_busy = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("to_rst_memerr", 32'(hif1.MemErr), 0);
    check("to_rst_stallf", 32'(hif1.StallF), 0);
    check("to_rst_cnt",    32'(hif1.StallCnt), 0);
    mem_busy = 1'b0;
    tick();
    rst = 1'b0;

    // Saturation: ten stalled cycles against a 3-bit counter.
    mem_busy = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("sat_reach", 32'(hif1.StallCnt), 7);
    tick(); tick(); tick();
    check("sat_hold",  32'(hif1.StallCnt), 7);
    check("sat_wide",  32'(hif0.StallCnt), 10);
    check("sat_flush", 32'(hif1.FlushCnt), 0);
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
